aes_cbc_decipher_ctrl: RTL and testbench
========================================

// Module: aes_cbc_decipher_ctrl
// PURPOSE
//  Stream-side controller wrapped around the AES decipher block: accepts ciphertext via valid/ready,
//  drives the core's next/block/keylen, waits for core ready, applies CBC chaining
//  (pt = D(ct) ^ prev_ct), presents plaintext via valid/ready. One block in flight; key memory is external.
// PARAMETERS
//  WDOG_CYCLES  128  cycles in WAIT before err sets; 0 disables watchdog
// PORTS
//  clk            in   1    clock
//  reset_n        in   1    reset, asynchronous, active-low
//  keylen         in   1    0=AES-128, 1=AES-256; sampled on input accept
//  iv_we          in   1    load iv into chain register (honoured in IDLE only)
//  iv             in   128  initialisation vector
//  in_valid       in   1    ciphertext valid
//  in_ready       out  1    controller can accept ciphertext
//  in_data        in   128  ciphertext block
//  core_next      out  1    one-cycle start pulse to decipher core
//  core_keylen    out  1    keylen latched for current block
//  core_block     out  128  ciphertext held for core
//  core_ready     in   1    core idle/done
//  core_new_block in   128  core decrypted output
//  out_valid      out  1    plaintext valid
//  out_ready      in   1    downstream accepts plaintext
//  out_data       out  128  plaintext block
//  err            out  1    sticky watchdog error
//  err_clr        in   1    clears err
// BEHAVIOUR
//  - Reset: in_ready=0, core_next=0, core_keylen=0, core_block=0, out_valid=0, out_data=0,
//    err=0, chain=0, state=IDLE. After reset, in_ready=1 from the first clocked cycle.
//  - FSM IDLE->START->WAIT->OUT->IDLE.
//  - IDLE: in_ready=core_ready. in_valid&&in_ready: ct_reg<=in_data, core_keylen<=keylen, ->START.
//  - START: core_next=1 for exactly one cycle; core_block=ct_reg, stable until block returns to IDLE; ->WAIT.
//  - WAIT: core_ready is ignored in the first WAIT cycle (core drops ready on the edge after next).
//    From the second cycle on, core_ready=1 does all of the following at the same edge:
//    out_data<=core_new_block^chain, chain<=ct_reg, out_valid<=1, ->OUT.
//  - OUT: out_data is held until out_valid&&out_ready, then out_valid<=0 and ->IDLE.
//    Next block is accepted one cycle later at the earliest.
//  - iv_we in IDLE: chain<=iv. If iv_we and accept fall in the same cycle, the new iv applies to that block.
//    iv_we in any other state is ignored.
//  - Watchdog: 8-bit counter cleared on entry to WAIT, increments each WAIT cycle.
//    When it reaches WDOG_CYCLES, err<=1 (sticky); FSM keeps waiting.
//    err_clr clears err. err_clr with a simultaneous expiry leaves err=1.
//  - Reset mid-operation: all state returns to reset values at once; the in-flight block is dropped.
// CONFIGURATION
//  - AES_CBC_DEC_CHAIN_EN defined: CBC chaining as above.
//  - Undefined (ECB): out_data<=core_new_block. Chain register and iv path are removed;
//    iv_we and iv are ignored.
// STRUCTURE
//  - Shared package/include aes_defs: AES_128_BIT_KEY/AES_256_BIT_KEY, controller state encodings
//    (IDLE=0, START=1, WAIT=2, OUT=3).
//  - Sub-module aes_wdog_ctr: clear/enable/limit counter producing the expiry pulse.
// TESTING
//  - ECB vs FIPS-197: key 000102..0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data
//    00112233445566778899aabbccddeeff, core_next pulse 1 cycle.
//  - CBC, iv=000102..0f, SP800-38A F.2.1 ct1 7649abac8119b246cee98e9b12e9197d ->
//    pt1 6bc1bee22e409f96e93d7e117393172a; ct2 then uses chain=ct1.
//  - Backpressure: hold out_ready=0 for 10 cycles -> out_data stable, in_ready=0, no second core_next.
//  - iv_we while in WAIT -> ignored; same-cycle iv_we+accept in IDLE -> new iv used.
//  - Stub core holds core_ready=0 for 200 cycles -> err=1 after 128 WAIT cycles;
//    err_clr -> err=0; late ready still completes the block.
//  - Assert reset_n low in WAIT -> all outputs return to reset values at once;
//    a fresh block after reset decrypts correctly.

Source files
------------

// File: rtl/aes_defs.sv
// aes_defs: shared key-length codes and controller state encodings
// for the AES decipher stream controller.
package aes_defs;

  localparam logic AES_128_BIT_KEY = 1'b0;
  localparam logic AES_256_BIT_KEY = 1'b1;

  localparam int WDOG_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/aes_wdog_ctr.sv
// aes_wdog_ctr: saturating wait counter with a one-cycle expiry pulse
// when the count reaches LIMIT; LIMIT of zero never expires.
module aes_wdog_ctr #(
  parameter int W     = 8,
  parameter int LIMIT = 128
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic first,
  output logic expire
);

  logic [W-1:0] cnt;

  // count enabled cycles, clear outside the window, saturate at all-ones
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign first = (cnt == '0);

  generate
    if (LIMIT == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      localparam logic [W-1:0] LIM_M1 = W'(LIMIT - 1);
      assign expire = en && (cnt == LIM_M1);
    end
  endgenerate

endmodule

// File: rtl/aes_cbc_decipher_ctrl.sv
// aes_cbc_decipher_ctrl: stream controller around the AES decipher core.
// Define AES_CBC_DEC_CHAIN_EN for CBC chaining; ECB when undefined.
module aes_cbc_decipher_ctrl
  import aes_defs::*;
#(
  parameter int WDOG_CYCLES = 128
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         keylen,
  input  logic         iv_we,
  input  logic [127:0] iv,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         core_next,
  output logic         core_keylen,
  output logic [127:0] core_block,
  input  logic         core_ready,
  input  logic [127:0] core_new_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         err,
  input  logic         err_clr
);

  ctrl_state_t  state_q, state_d;
  logic         live_q;
  logic [127:0] ct_q;
  logic         kl_q;
  logic [127:0] od_q;
  logic         ov_q;
  logic         err_q;
  logic         accept, done, hand;
  logic         first, expire;
  logic [127:0] pt;

  aes_wdog_ctr #(
    .W     (WDOG_W),
    .LIMIT (WDOG_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state_q != ST_WAIT),
    .en      (state_q == ST_WAIT),
    .first   (first),
    .expire  (expire)
  );

  // next state, handshakes and core start pulse
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    core_next = 1'b0;
    accept    = 1'b0;
    done      = 1'b0;
    hand      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = live_q && core_ready;
        if (in_valid && in_ready) begin
          accept  = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        core_next = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (!first && core_ready) begin
          done    = 1'b1;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          hand    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state register; live_q holds in_ready low until the first edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

`ifdef AES_CBC_DEC_CHAIN_EN
  logic [127:0] chain_q;

  // chain register: iv load in IDLE, previous ciphertext after each block
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_q <= '0;
    end else if ((state_q == ST_IDLE) && iv_we) begin
      chain_q <= iv;
    end else if (done) begin
      chain_q <= ct_q;
    end
  end

  assign pt = core_new_block ^ chain_q;
`else
  logic unused_iv;
  assign unused_iv = ^{iv_we, iv};
  assign pt = core_new_block;
`endif

  // block capture and plaintext output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ct_q <= '0;
      kl_q <= AES_128_BIT_KEY;
      od_q <= '0;
      ov_q <= 1'b0;
    end else begin
      if (accept) begin
        ct_q <= in_data;
        kl_q <= keylen;
      end
      if (done) begin
        od_q <= pt;
        ov_q <= 1'b1;
      end else if (hand) begin
        ov_q <= 1'b0;
      end
    end
  end

  // sticky watchdog error; expiry wins over a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (expire) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign core_block  = ct_q;
  assign core_keylen = kl_q;
  assign out_valid   = ov_q;
  assign out_data    = od_q;
  assign err         = err_q;

endmodule

// File: tb/tb_aes_cbc_decipher_ctrl.sv
// tb_aes_cbc_decipher_ctrl: stub-core bench with a block-level model
// of the controller, checked on every negative clock edge.
module tb_aes_cbc_decipher_ctrl;

  localparam int WDOG = 128;

  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] IV0     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1     = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] PT1     = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT2     = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] PT2     = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] ECB1    = 128'h6bc0bce12a459991e134741a7f9e1925;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         keylen;
  logic         iv_we;
  logic [127:0] iv;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         core_next;
  logic         core_keylen;
  logic [127:0] core_block;
  logic         core_ready;
  logic [127:0] core_new_block;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         err;
  logic         err_clr;

  int errors = 0;
  int checks = 0;
  int nx_cnt = 0;

  int  stub_lat  = 0;
  bit  stub_lazy = 0;
  bit  idle_drop = 0;

  aes_cbc_decipher_ctrl #(.WDOG_CYCLES(WDOG)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .keylen         (keylen),
    .iv_we          (iv_we),
    .iv             (iv),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .core_next      (core_next),
    .core_keylen    (core_keylen),
    .core_block     (core_block),
    .core_ready     (core_ready),
    .core_new_block (core_new_block),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .err            (err),
    .err_clr        (err_clr)
  );

  always #5 clk = ~clk;

  // stand-in for the AES decipher: known vectors plus a fixed mixing map
  function automatic logic [127:0] dec(input logic [127:0] x);
    if (x == FIPS_CT) return FIPS_PT;
    if (x == CT1) return PT1 ^ IV0;
    if (x == CT2) return PT2 ^ CT1;
    return {x[63:0], x[127:64]} ^ 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got no event want event", nm);
  endtask

  // stub core: latches block on next, drops ready, returns after stub_lat
  initial begin : stub
    logic         nx;
    logic [127:0] blkv, sblk;
    bit           sbusy, sdrop;
    int           left;
    core_ready     = 1'b1;
    core_new_block = '0;
    sbusy = 0; sdrop = 0; left = 0; sblk = '0;
    forever begin
      @(negedge clk);
      nx   = core_next;
      blkv = core_block;
      @(posedge clk);
      #1;
      if (!reset_n) begin
        core_ready = 1'b1;
        sbusy = 0;
        sdrop = 0;
      end else begin
        if (sdrop) begin
          core_ready = 1'b0;
          sdrop = 0;
        end else if (sbusy) begin
          if (left > 0) left--;
          else begin
            core_ready     = 1'b1;
            core_new_block = dec(sblk);
            sbusy = 0;
          end
        end else begin
          core_ready = idle_drop ? ($urandom_range(0, 7) != 0) : 1'b1;
        end
        if (nx) begin
          sblk  = blkv;
          sbusy = 1;
          left  = stub_lat;
          if (stub_lazy) begin
            core_ready = 1'b1;
            sdrop = 1;
          end else begin
            core_ready = 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clk) if (reset_n && core_next) nx_cnt++;

  // block-level reference model and per-cycle comparison
  bit           m_started, m_busy, m_next, m_ov, m_err, m_kl;
  int unsigned  m_wait;
  logic [127:0] m_ct, m_od, m_chain;

  always @(negedge clk) begin : model
    bit idle, acc, m_exp;
    if (!reset_n) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_core_next", core_next, 0);
      chk("rst_core_keylen", core_keylen, 0);
      chk("rst_core_block", core_block, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_err", err, 0);
      m_started = 0; m_busy = 0; m_next = 0; m_ov = 0;
      m_err = 0; m_kl = 0; m_wait = 0;
      m_ct = '0; m_od = '0; m_chain = '0;
    end else begin
      chk("in_ready", in_ready, m_started && !m_busy && core_ready);
      chk("core_next", core_next, m_next);
      chk("core_block", core_block, m_ct);
      chk("core_keylen", core_keylen, m_kl);
      chk("out_valid", out_valid, m_ov);
      chk("out_data", out_data, m_od);
      chk("err", err, m_err);
      idle  = !m_busy;
      acc   = idle && m_started && core_ready && in_valid;
      m_exp = 0;
      if (m_next) begin
        m_next = 0;
        m_wait = 1;
      end else if (m_wait > 0) begin
        if (WDOG != 0 && m_wait == WDOG) m_exp = 1;
        if (m_wait >= 2 && core_ready) begin
`ifdef AES_CBC_DEC_CHAIN_EN
          m_od = dec(m_ct) ^ m_chain;
`else
          m_od = dec(m_ct);
`endif
          m_chain = m_ct;
          m_ov    = 1;
          m_wait  = 0;
        end else if (m_wait < 100000) begin
          m_wait++;
        end
      end else if (m_ov && out_ready) begin
        m_ov   = 0;
        m_busy = 0;
      end
      if (m_exp) m_err = 1;
      else if (err_clr) m_err = 0;
      if (idle && iv_we) m_chain = iv;
      if (acc) begin
        m_ct   = in_data;
        m_kl   = keylen;
        m_busy = 1;
        m_next = 1;
      end
      m_started = 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] ct, input logic kl,
                      input logic ivwe, input logic [127:0] ivv);
    int n;
    in_valid = 1'b1;
    in_data  = ct;
    keylen   = kl;
    iv_we    = ivwe;
    iv       = ivv;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 1000) begin
        timeout("send");
        break;
      end
    end
    tick();
    in_valid = 1'b0;
    iv_we    = 1'b0;
  endtask

  task automatic recv(output logic [127:0] res);
    int n;
    out_ready = 1'b1;
    res = '0;
    n = 0;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        res = out_data;
        break;
      end
      n++;
      if (n > 1000) begin
        timeout("recv");
        break;
      end
    end
    tick();
    out_ready = 1'b0;
  endtask

  initial begin : main
    logic [127:0] r, a, b, x, hold;
    int           nb;
    reset_n  = 1'b0;
    keylen   = 1'b0;
    iv_we    = 1'b0;
    iv       = '0;
    in_valid = 1'b0;
    in_data  = '0;
    out_ready = 1'b0;
    err_clr  = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // FIPS-197 vector, chain is zero after reset in either build
    nb = nx_cnt;
    send(FIPS_CT, 1'b0, 1'b0, '0);
    recv(r);
    chk("fips_pt", r, FIPS_PT);
    chk("next_pulses", nx_cnt - nb, 1);

    // iv load in the accept cycle applies to this block
    send(CT1, 1'b1, 1'b1, IV0);
    recv(r);
`ifdef AES_CBC_DEC_CHAIN_EN
    chk("cbc_pt1", r, PT1);
`else
    chk("ecb_ct1", r, ECB1);
`endif
    send(CT2, 1'b0, 1'b0, '0);
    recv(r);
`ifdef AES_CBC_DEC_CHAIN_EN
    chk("cbc_pt2", r, PT2);
`else
    chk("ecb_ct2", r, PT2 ^ CT1);
`endif

    // backpressure: plaintext held, nothing accepted, no new start
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    send(a, 1'b1, 1'b0, '0);
    in_valid = 1'b1;
    in_data  = b;
    repeat (4) tick();
    hold = dec(a);
`ifdef AES_CBC_DEC_CHAIN_EN
    hold = hold ^ CT2;
`endif
    nb = nx_cnt;
    repeat (10) begin
      @(negedge clk);
      chk("bp_data", out_data, hold);
      chk("bp_in_ready", in_ready, 0);
    end
    chk("bp_no_next", nx_cnt - nb, 0);
    tick();
    recv(r);
    send(b, 1'b0, 1'b0, '0);
    recv(r);

    // iv_we during WAIT is ignored
    stub_lat = 20;
    x = {$urandom, $urandom, $urandom, $urandom};
    send(x, 1'b0, 1'b0, '0);
    repeat (3) tick();
    iv_we = 1'b1;
    iv    = {$urandom, $urandom, $urandom, $urandom};
    repeat (5) tick();
    iv_we = 1'b0;
    recv(r);
`ifdef AES_CBC_DEC_CHAIN_EN
    chk("iv_in_wait", r, dec(x) ^ b);
`else
    chk("iv_in_wait", r, dec(x));
`endif

    // watchdog: stalled core sets err, clear works, late ready completes
    stub_lat = 200;
    a = {$urandom, $urandom, $urandom, $urandom};
    send(a, 1'b0, 1'b0, '0);
    repeat (135) @(negedge clk);
    chk("wdog_err_set", err, 1);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    chk("wdog_err_clr", err, 0);
    tick();
    recv(r);
`ifdef AES_CBC_DEC_CHAIN_EN
    chk("wdog_late_pt", r, dec(a) ^ x);
`else
    chk("wdog_late_pt", r, dec(a));
`endif

    // clear held across the expiry: expiry edge still sets err
    stub_lat = 140;
    err_clr  = 1'b1;
    send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, '0);
    recv(r);
    err_clr = 1'b0;

    // reset in WAIT drops the block; fresh block decrypts from zero chain
    stub_lat = 30;
    send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, '0);
    repeat (5) tick();
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ov", out_valid, 0);
    repeat (2) tick();
    reset_n  = 1'b1;
    stub_lat = 0;
    tick();
    send(FIPS_CT, 1'b0, 1'b0, '0);
    recv(r);
    chk("post_rst_fips", r, FIPS_PT);

    // randomized traffic against the model
    idle_drop = 1;
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      keylen    = $urandom_range(0, 1);
      iv_we     = ($urandom_range(0, 7) == 0);
      iv        = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 2) != 0);
      err_clr   = ($urandom_range(0, 15) == 0);
      stub_lat  = $urandom_range(0, 5);
      stub_lazy = ($urandom_range(0, 1) == 1);
      tick();
    end
    in_valid  = 1'b0;
    iv_we     = 1'b0;
    err_clr   = 1'b0;
    out_ready = 1'b1;
    repeat (40) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
